// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: default widths, ALU op
// encodings and the control word carried down the pipe with its bubble value.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_OP_W   = 3;

  localparam logic [DEF_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [DEF_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [DEF_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [DEF_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [DEF_OP_W-1:0] ALU_SLT = 3'b100;

  // Control bits that travel with an instruction through EX.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  // A bubble does nothing: not valid, writes nothing, touches no memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/forward_sel.sv
// Per-operand forwarding mux.
// Ports: i_reg (source register number), i_rf_data (registered file data),
//        i_exmem_* / i_memwb_* (producer write info), o_data (selected operand).
// EX/MEM beats MEM/WB; register 0 is never forwarded.
module forward_sel #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic [REG_W-1:0]  i_reg,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_exmem_reg_write,
  input  logic [REG_W-1:0]  i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [REG_W-1:0]  i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_result,
  output logic [DATA_W-1:0] o_data
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_hit_exmem = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_reg);
  assign w_hit_memwb = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_reg);

  // Later assignment wins, so EX/MEM is checked last.
  always_comb begin
    o_data = i_rf_data;
    if (w_hit_memwb) o_data = i_memwb_result;
    if (w_hit_exmem) o_data = i_exmem_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Inputs : id_* decoded fields, stall_in/flush, EX/MEM and MEM/WB producer info.
// Outputs: lop/rop/alu_op to the ALU, store_data, ex_dest, ex_* control bits,
//          load_use_stall (combinational) to hold PC and IF/ID.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] lop,
  output logic [DATA_W-1:0] rop,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_stall
);

  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_alu_src;
  logic              r_reg_dst;

  logic [REG_W-1:0]  w_dest;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic              w_load_use;
  logic              w_bubble;

  assign w_dest = r_reg_dst ? r_rd : r_rt;

  // A load in EX whose result an ID instruction needs next cycle; a flush
  // kills the load, so there is nothing to wait for.
  assign w_load_use = !flush && r_ctrl.valid && r_ctrl.mem_read && (w_dest != '0) &&
                      id_valid && ((w_dest == id_rs) || (id_uses_rt && (w_dest == id_rt)));

  // Flush wins over stall; a load-use bubble only loads when not stalled.
  assign w_bubble = flush || (!stall_in && w_load_use);

  // ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_alu_op  <= OP_W'(ALU_ADD);
      r_alu_src <= 1'b0;
      r_reg_dst <= 1'b0;
    end else if (w_bubble) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_alu_op  <= OP_W'(ALU_ADD);
      r_alu_src <= 1'b0;
      r_reg_dst <= 1'b0;
    end else if (!stall_in) begin
      r_ctrl    <= '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read,
                     mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_alu_op  <= id_alu_op;
      r_alu_src <= id_alu_src;
      r_reg_dst <= id_reg_dst;
    end
  end

  forward_sel #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_a (
    .i_reg             (r_rs),
    .i_rf_data         (r_rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_a)
  );

  forward_sel #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_b (
    .i_reg             (r_rt),
    .i_rf_data         (r_rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_b)
  );

  // Stores always need the forwarded rt, even when rop takes the immediate.
  assign lop            = w_fwd_a;
  assign rop            = r_alu_src ? r_imm : w_fwd_b;
  assign store_data     = w_fwd_b;
  assign alu_op         = r_alu_op;
  assign ex_dest        = w_dest;
  assign ex_valid       = r_ctrl.valid;
  assign ex_reg_write   = r_ctrl.reg_write;
  assign ex_mem_read    = r_ctrl.mem_read;
  assign ex_mem_write   = r_ctrl.mem_write;
  assign ex_mem_to_reg  = r_ctrl.mem_to_reg;
  assign load_use_stall = w_load_use;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage, sitting directly upstream of the ALU.
- Captures decoded instruction fields from ID each cycle.
- Resolves EX/MEM and MEM/WB forwarding and drives the ALU's lop, rop and op.
- Detects load-use hazards, requests an ID stall and inserts a bubble.

Parameters:
DATA_W, 32, datapath width (ALU operands, immediate, forwarded results)
REG_W, 5, register-file address width
OP_W, 3, ALU op width (Add=000, Sub=001, And=010, Or=011, Slt=100)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_W  source and destination register numbers
id_uses_rt  in  1  instruction reads rt as an operand (R-type or store)
id_alu_op  in  OP_W  ALU operation
id_alu_src  in  1  1 = rop is immediate
id_reg_dst  in  1  1 = destination is rd, 0 = rt
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
stall_in  in  1  downstream hold
flush  in  1  squash the EX slot (branch taken)
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_W  EX/MEM destination register
exmem_result  in  DATA_W  EX/MEM result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_W  MEM/WB destination register
memwb_result  in  DATA_W  MEM/WB write-back data
lop, rop  out  DATA_W  ALU operands
alu_op  out  OP_W  ALU operation
store_data  out  DATA_W  forwarded rt value for stores
ex_dest  out  REG_W  selected destination register
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control bits
load_use_stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_n low, asynchronous): all registered state clears to 0, giving alu_op=Add and ex_valid=0 with all control bits 0. Outputs follow the forwarding rules on the zeroed state.
- Register update priority at each rising edge: flush > stall_in > load_use_stall > normal load.
  - flush: load a bubble (valid and all control bits 0, data 0, alu_op=Add).
  - stall_in: hold all registered state.
  - load_use_stall: load a bubble; ID holds upstream.
  - normal: capture all id_* fields; ex_valid <= id_valid.
- Latency: one cycle from ID inputs to registered fields. Forwarding and operand selection are combinational off registered state.
- load_use_stall (combinational) is 1 when all of the following hold:
  - ex_valid & ex_mem_read
  - ex_dest != 0
  - id_valid
  - ex_dest == id_rs, or (id_uses_rt and ex_dest == id_rt)
- load_use_stall is forced to 0 while flush is 1.
- ex_dest = reg_dst ? rd : rt.
- Forwarding for operand A (rs) and operand B (rt) applies the first matching rule:
  1. exmem_reg_write & exmem_rd != 0 & exmem_rd == reg → exmem_result
  2. memwb_reg_write & memwb_rd != 0 & memwb_rd == reg → memwb_result
  3. otherwise the registered register-file data
- Register 0 is never forwarded.
- When EX/MEM and MEM/WB both match the same register, EX/MEM wins.
- Operand outputs:
  - lop = fwd_a
  - rop = alu_src ? imm : fwd_b
  - store_data = fwd_b (always forwarded, even when alu_src=1)
- Forwarding is qualified only by the producers' reg_write. Bubbles carry reg_write=0 and therefore never forward.
- No arithmetic in this block. Widths pass straight through; there is no extension beyond the ID-supplied immediate.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - DATA_W and REG_W defaults
  - the bubble control-word constant
- One natural sub-module, forward_sel: combinational per-operand forwarding mux, instantiated twice (rs, rt).

Test Plan:
1. Reset: drive rst_n=0 mid-cycle with stale state loaded → all outputs clear immediately (ex_valid=0, alu_op=000, lop=rop=0), without waiting for a clock edge.
2. EX/MEM forward with immediate select: EX holds add with rs=8; exmem_rd=8, exmem_result=0x10, exmem_reg_write=1; alu_src=1, imm=0xFFFFFFFC → lop=0x10, rop=0xFFFFFFFC.
3. Double hazard: exmem_rd=memwb_rd=9, results 0xAA and 0xBB, EX rt=9, alu_src=0 → rop=0xAA. Repeat with exmem_reg_write=0 → rop=0xBB. Repeat with register 0 as the match → register-file data is used.
4. Load-use: EX holds lw with dest 5; ID has rs=5, id_valid=1 → load_use_stall=1, and the next EX is a bubble (ex_valid=0, ex_reg_write=0). Repeat with ID rt=5 and id_uses_rt=0 → load_use_stall=0.
5. Flush vs stall: flush=1 and stall_in=1 together → bubble loaded. stall_in=1 alone for 3 cycles → EX fields unchanged while id_* toggle.
6. Store forwarding: EX holds sw with rt=4, alu_src=1; memwb_rd=4, memwb_result=0x1234 → store_data=0x1234 and rop=imm.
